image_pipe_rst_seq: RTL

DUT-side counterpart of the testbench reset interface. It consumes the synchronous system reset and the register-CPU reset request, and generates the sequenced, registered resets that the image pipe actually uses.
- reg_cpu_rst is held for a fixed hold time, then released.
- Per-stage pipeline resets are then released sink-first at a fixed spacing.
- rst_busy and rst_done report sequence status to the register block.
- A software pipeline-only reset path is included.

---
 rtl/image_pipe_rst_pkg.sv | 14 +
 rtl/image_pipe_rst_seq.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/image_pipe_rst_pkg.sv
// Shared types and default sizing for the image pipe reset sequencer.
package image_pipe_rst_pkg;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } rst_state_e;

    localparam int unsigned N_STAGES_DEF    = 4;
    localparam int unsigned HOLD_CYCLES_DEF = 16;
    localparam int unsigned STAGE_GAP_DEF   = 2;

endpackage

// File: rtl/image_pipe_rst_seq.sv
// Sequenced reset generator: holds reg/CPU and pipe resets, then releases the
// pipe stages sink-first at a fixed spacing; supports a pipe-only soft reset.
module image_pipe_rst_seq
    import image_pipe_rst_pkg::*;
#(
    parameter int unsigned N_STAGES    = N_STAGES_DEF,
    parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int unsigned STAGE_GAP   = STAGE_GAP_DEF
) (
    input  logic                clk,
    input  logic                s_rst,
    input  logic                reg_cpu_rst_req,
    input  logic                sw_rst_req,
    output logic                reg_cpu_rst,
    output logic [N_STAGES-1:0] pipe_rst,
    output logic                rst_busy,
    output logic                rst_done
);

    localparam int unsigned CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned STG_W   = $clog2(N_STAGES + 1);

    rst_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [STG_W-1:0]    stage_q, stage_d;
    logic                reg_cpu_rst_q, reg_cpu_rst_d;
    logic [N_STAGES-1:0] pipe_rst_q, pipe_rst_d;
    logic                rst_busy_q, rst_busy_d;
    logic                rst_done_q, rst_done_d;

    logic hold_end;
    logic gap_end;
    logic last_stage;

    assign hold_end   = (cnt_q == CNT_W'(HOLD_CYCLES - 1));
    assign gap_end    = (cnt_q == CNT_W'(STAGE_GAP - 1));
    // stage_q counts pipe bits still asserted once RELEASE has begun
    assign last_stage = (stage_q == STG_W'(1));

    // State and output registers
    always_ff @(posedge clk) begin
        if (s_rst) begin
            state_q       <= ASSERT;
            cnt_q         <= '0;
            stage_q       <= STG_W'(N_STAGES - 1);
            reg_cpu_rst_q <= 1'b1;
            pipe_rst_q    <= '1;
            rst_busy_q    <= 1'b1;
            rst_done_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stage_q       <= stage_d;
            reg_cpu_rst_q <= reg_cpu_rst_d;
            pipe_rst_q    <= pipe_rst_d;
            rst_busy_q    <= rst_busy_d;
            rst_done_q    <= rst_done_d;
        end
    end

    // Next state, hold/gap counter and remaining-stage index
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        if (reg_cpu_rst_req || sw_rst_req) begin
            state_d = ASSERT;
            cnt_d   = '0;
            stage_d = STG_W'(N_STAGES - 1);
        end else begin
            case (state_q)
                ASSERT: begin
                    if (hold_end) begin
                        cnt_d   = '0;
                        stage_d = STG_W'(N_STAGES - 1);
                        state_d = (N_STAGES == 1) ? RUN : RELEASE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (gap_end) begin
                        cnt_d   = '0;
                        stage_d = stage_q - STG_W'(1);
                        if (last_stage) state_d = RUN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered outputs; sw_rst_req leaves reg_cpu_rst untouched
    always_comb begin
        reg_cpu_rst_d = reg_cpu_rst_q;
        pipe_rst_d    = pipe_rst_q;
        rst_busy_d    = rst_busy_q;
        rst_done_d    = 1'b0;
        if (reg_cpu_rst_req) begin
            reg_cpu_rst_d = 1'b1;
            pipe_rst_d    = '1;
            rst_busy_d    = 1'b1;
        end else if (sw_rst_req) begin
            pipe_rst_d = '1;
            rst_busy_d = 1'b1;
        end else begin
            case (state_q)
                ASSERT: begin
                    if (hold_end) begin
                        reg_cpu_rst_d            = 1'b0;
                        pipe_rst_d[N_STAGES-1]   = 1'b0;
                        if (N_STAGES == 1) begin
                            rst_busy_d = 1'b0;
                            rst_done_d = 1'b1;
                        end
                    end
                end
                RELEASE: begin
                    // asserted bits are always a contiguous low-order run
                    if (gap_end) begin
                        pipe_rst_d = pipe_rst_q >> 1;
                        if (last_stage) begin
                            rst_busy_d = 1'b0;
                            rst_done_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign reg_cpu_rst = reg_cpu_rst_q;
    assign pipe_rst    = pipe_rst_q;
    assign rst_busy    = rst_busy_q;
    assign rst_done    = rst_done_q;

endmodule
